// File: rtl/spi_pkg.sv
// Shared widths, defaults and state encoding for the SPI responder byte shifter.
package spi_pkg;

   localparam int BYTE_W   = 8;
   localparam int BITCNT_W = 3;

   // Byte shifted out whenever no transmit byte has been supplied in time.
   localparam logic [BYTE_W-1:0] DEFAULT_IDLE_BYTE = 8'hFF;

   // IDLE: not selected, bus edges ignored. ACTIVE: cs_n low, shifting.
   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous bus pin; reset value is selectable
// so an idle-high pin (cs_n) does not look like an edge when reset releases.
module sync_ff #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   // Shift the pin through STAGES flops; the oldest flop is the output.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sr <= {STAGES{RESET_VAL}};
      end else begin
         sr <= {sr[STAGES-2:0], d};
      end
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/spi_resp_bs.sv
// SPI mode-0 responder byte shifter, MSB first. The bus pins are oversampled
// on the system clock; sclk is treated purely as data. Received bytes appear
// with a one-cycle rx_v pulse, transmit bytes go through a one-entry holding
// register with a valid/ready handshake.
//
// Handshake: a tx_data byte is transferred on any clock where tx_v and
// tx_ready are both high; tx_v may be held high until that happens. At a
// byte-boundary load with the holding register empty, a tx_v present in that
// very cycle is taken straight into the shift register (bypass).
module spi_resp_bs
   import spi_pkg::*;
#(
   parameter int                SYNC_STAGES = 2,
   parameter logic [BYTE_W-1:0] IDLE_BYTE   = DEFAULT_IDLE_BYTE
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              sclk,
   input  logic              mosi,
   input  logic              cs_n,
   output logic              miso,
   output logic              miso_oe,
   input  logic [BYTE_W-1:0] tx_data,
   input  logic              tx_v,
   output logic              tx_ready,
   output logic              tx_underrun,
   output logic [BYTE_W-1:0] rx_data,
   output logic              rx_v,
   output logic              selected
);

   logic sclk_s, mosi_s, cs_n_s;
   logic sclk_d, cs_n_d;
   logic sclk_rise, sclk_fall, cs_fall, cs_rise;
   logic load_evt;
   logic shift_evt;
   logic rise_evt;

   spi_state_e          state_q;
   logic [BITCNT_W-1:0] bit_cnt;
   logic [BYTE_W-1:0]   rx_sr;
   logic [BYTE_W-1:0]   tx_sr;
   logic [BYTE_W-1:0]   hold;
   logic                hold_full;

   sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clock (clock),
      .reset (reset),
      .d     (sclk),
      .q     (sclk_s)
   );

   sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clock (clock),
      .reset (reset),
      .d     (mosi),
      .q     (mosi_s)
   );

   sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
      .clock (clock),
      .reset (reset),
      .d     (cs_n),
      .q     (cs_n_s)
   );

   // One-flop delayed copies of the synchronized sclk/cs_n for edge detection.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sclk_d <= 1'b0;
         cs_n_d <= 1'b1;
      end else begin
         sclk_d <= sclk_s;
         cs_n_d <= cs_n_s;
      end
   end

   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_fall   = ~cs_n_s & cs_n_d;
   assign cs_rise   = cs_n_s & ~cs_n_d;

   // Bus edges only count while selected and not in the cycle selection ends.
   assign rise_evt  = (state_q == ACTIVE) && !cs_rise && sclk_rise;
   assign shift_evt = (state_q == ACTIVE) && !cs_rise && sclk_fall && (bit_cnt != '0);

   // A new byte is loaded on selection and at the first fall of each byte slot.
   assign load_evt  = ((state_q == IDLE) && cs_fall) ||
                      ((state_q == ACTIVE) && !cs_rise && sclk_fall && (bit_cnt == '0));

   assign selected = (state_q == ACTIVE);
   assign miso_oe  = selected;
   assign miso     = tx_sr[BYTE_W-1];
   assign tx_ready = ~hold_full;

   // Selection state: enter on cs_n fall, leave on cs_n rise from any point.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE:    if (cs_fall) state_q <= ACTIVE;
            ACTIVE:  if (cs_rise) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Receive path: sample mosi on each rise, publish a byte on the 8th rise.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bit_cnt <= '0;
         rx_sr   <= '0;
         rx_data <= '0;
         rx_v    <= 1'b0;
      end else begin
         rx_v <= 1'b0;
         if ((state_q == ACTIVE) && cs_rise) begin
            // Deselect mid-byte drops the partial byte silently.
            bit_cnt <= '0;
            rx_sr   <= '0;
         end else if ((state_q == IDLE) && cs_fall) begin
            bit_cnt <= '0;
         end else if (rise_evt) begin
            rx_sr   <= {rx_sr[BYTE_W-2:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               rx_data <= {rx_sr[BYTE_W-2:0], mosi_s};
               rx_v    <= 1'b1;
            end
         end
      end
   end

   // Transmit path: holding register, load/bypass/underrun, and MSB-first shift.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_sr       <= IDLE_BYTE;
         hold        <= '0;
         hold_full   <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         tx_underrun <= 1'b0;
         if (load_evt) begin
            if (hold_full) begin
               tx_sr     <= hold;
               hold_full <= 1'b0;
            end else if (tx_v) begin
               tx_sr <= tx_data;
            end else begin
               tx_sr       <= IDLE_BYTE;
               tx_underrun <= 1'b1;
            end
         end else begin
            if (tx_v && !hold_full) begin
               hold      <= tx_data;
               hold_full <= 1'b1;
            end
            if ((state_q == ACTIVE) && cs_rise) begin
               // Deselect discards the byte in flight; the holding register survives.
               tx_sr <= IDLE_BYTE;
            end else if (shift_evt) begin
               tx_sr <= {tx_sr[BYTE_W-2:0], 1'b1};
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_resp_bs.sv
// Bench for spi_resp_bs: a mode-0 initiator drives the bus pins, expected
// miso and rx bytes are queued as stimulus is issued, and independent
// monitors pop and compare them as the DUT produces them.
module tb_spi_resp_bs;

   localparam int HALF = 8;   // clock periods per sclk phase

   logic       clock;
   logic       reset;
   logic       sclk;
   logic       mosi;
   logic       cs_n;
   logic       miso;
   logic       miso_oe;
   logic [7:0] tx_data;
   logic       tx_v;
   logic       tx_ready;
   logic       tx_underrun;
   logic [7:0] rx_data;
   logic       rx_v;
   logic       selected;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_rx_q[$];
   logic [7:0] exp_miso_q[$];

   int         underrun_seen = 0;
   int         exp_underrun  = 0;
   int         rx_seen       = 0;
   int         exp_rx_cnt    = 0;
   int         mon_bits      = 0;
   logic [7:0] mon_byte      = '0;

   spi_resp_bs dut (
      .clock       (clock),
      .reset       (reset),
      .sclk        (sclk),
      .mosi        (mosi),
      .cs_n        (cs_n),
      .miso        (miso),
      .miso_oe     (miso_oe),
      .tx_data     (tx_data),
      .tx_v        (tx_v),
      .tx_ready    (tx_ready),
      .tx_underrun (tx_underrun),
      .rx_data     (rx_data),
      .rx_v        (rx_v),
      .selected    (selected)
   );

   // ---------------- clock / watchdog ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // miso monitor: the initiator samples miso on each sclk rise while selected.
   always @(posedge sclk or posedge cs_n) begin
      if (cs_n) begin
         mon_bits = 0;
      end else begin
         mon_byte = {mon_byte[6:0], miso};
         mon_bits++;
         if (mon_bits == 8) begin
            mon_bits = 0;
            if (exp_miso_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL miso_unexpected: got byte %0h with nothing expected", mon_byte);
            end else begin
               chk("miso_byte", {24'd0, mon_byte}, {24'd0, exp_miso_q.pop_front()});
            end
         end
      end
   end

   // rx monitor and pulse counters, sampled away from the active edge.
   always @(negedge clock) begin
      if (tx_underrun === 1'b1) underrun_seen++;
      if (rx_v === 1'b1) begin
         rx_seen++;
         if (exp_rx_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rx_unexpected: got rx_v with rx_data %0h, none expected", rx_data);
         end else begin
            chk("rx_byte", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tx_write(input logic [7:0] d);
      int n;
      n = 0;
      @(negedge clock);
      while (!tx_ready && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (n >= 200) begin
         checks++;
         failures++;
         $display("FAIL tx_write_timeout: tx_ready stayed %0b, required 1", tx_ready);
      end
      tx_data = d;
      tx_v    = 1'b1;
      @(negedge clock);
      tx_v    = 1'b0;
   endtask

   task automatic select_bus();
      @(negedge clock);
      cs_n = 1'b0;
      repeat (HALF) @(negedge clock);
   endtask

   task automatic deselect_bus();
      repeat (HALF) @(negedge clock);
      cs_n = 1'b1;
      repeat (HALF) @(negedge clock);
   endtask

   // Shift nbits of mo MSB first; returns right after the final sclk fall.
   task automatic spi_bits(input logic [7:0] mo, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         mosi = mo[i];
         repeat (HALF) @(negedge clock);
         sclk = 1'b1;
         repeat (HALF) @(negedge clock);
         sclk = 1'b0;
      end
   endtask

   task automatic spi_byte(input logic [7:0] mo, input logic [7:0] exp_miso);
      exp_miso_q.push_back(exp_miso);
      exp_rx_q.push_back(mo);
      exp_rx_cnt++;
      spi_bits(mo, 8);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset   = 1'b1;
      sclk    = 1'b0;
      mosi    = 1'b0;
      cs_n    = 1'b1;
      tx_data = '0;
      tx_v    = 1'b0;
      repeat (3) @(negedge clock);

      // Reset state
      chk("rst_miso",        {31'd0, miso},        32'd1);
      chk("rst_miso_oe",     {31'd0, miso_oe},     32'd0);
      chk("rst_selected",    {31'd0, selected},    32'd0);
      chk("rst_rx_data",     {24'd0, rx_data},     32'd0);
      chk("rst_rx_v",        {31'd0, rx_v},        32'd0);
      chk("rst_tx_underrun", {31'd0, tx_underrun}, 32'd0);
      chk("rst_tx_ready",    {31'd0, tx_ready},    32'd1);
      reset = 1'b0;
      repeat (4) @(negedge clock);

      // Basic exchange: preload A5, initiator sends 3C.
      tx_write(8'hA5);
      chk("basic_hold_full", {31'd0, tx_ready}, 32'd0);
      select_bus();
      chk("basic_selected", {31'd0, selected}, 32'd1);
      chk("basic_miso_oe",  {31'd0, miso_oe},  32'd1);
      chk("basic_ready",    {31'd0, tx_ready}, 32'd1);
      chk("basic_bit7",     {31'd0, miso},     32'd1);
      chk("basic_no_underrun", underrun_seen, 32'd0);
      spi_byte(8'h3C, 8'hA5);
      exp_underrun++;   // next slot starts empty
      deselect_bus();
      chk("basic_rx_data", {24'd0, rx_data}, 32'h3C);
      chk("basic_oe_off",  {31'd0, miso_oe}, 32'd0);
      chk("basic_underruns", underrun_seen, exp_underrun);

      // Underrun: select with nothing loaded.
      select_bus();
      exp_underrun++;
      chk("under_pulse", underrun_seen, exp_underrun);
      spi_byte(8'h81, 8'hFF);
      exp_underrun++;
      deselect_bus();
      chk("under_rx_data", {24'd0, rx_data}, 32'h81);
      chk("under_count",   underrun_seen, exp_underrun);

      // Back-to-back: 01 loads at select, 02 waits in the holding register.
      tx_write(8'h01);
      select_bus();
      tx_write(8'h02);
      chk("b2b_hold_full", {31'd0, tx_ready}, 32'd0);
      spi_byte(8'h55, 8'h01);
      spi_byte(8'hAA, 8'h02);
      exp_underrun++;
      deselect_bus();
      chk("b2b_rx_data", {24'd0, rx_data}, 32'hAA);
      chk("b2b_underruns", underrun_seen, exp_underrun);

      // Bypass: 7E offered exactly in the byte-boundary load cycle.
      tx_write(8'h33);
      select_bus();
      spi_byte(8'h0F, 8'h33);
      repeat (2) @(negedge clock);
      chk("byp_ready_before", {31'd0, tx_ready}, 32'd1);
      tx_data = 8'h7E;
      tx_v    = 1'b1;
      @(negedge clock);
      tx_v    = 1'b0;
      chk("byp_ready_after", {31'd0, tx_ready}, 32'd1);
      chk("byp_no_underrun", underrun_seen, exp_underrun);
      spi_byte(8'hF0, 8'h7E);
      exp_underrun++;
      deselect_bus();
      chk("byp_underruns", underrun_seen, exp_underrun);

      // Abort after 5 rises; held byte 69 must survive and start at bit 7.
      tx_write(8'hC3);
      select_bus();
      tx_write(8'h69);
      spi_bits(8'hE7, 5);
      deselect_bus();
      chk("abort_no_rx",   rx_seen, exp_rx_cnt);
      chk("abort_oe",      {31'd0, miso_oe},  32'd0);
      chk("abort_held",    {31'd0, tx_ready}, 32'd0);
      chk("abort_rx_data", {24'd0, rx_data},  32'hF0);
      select_bus();
      chk("abort_bit7", {31'd0, miso}, 32'd0);
      spi_byte(8'h12, 8'h69);
      exp_underrun++;
      deselect_bus();
      chk("abort_rx_after", {24'd0, rx_data}, 32'h12);
      chk("abort_underruns", underrun_seen, exp_underrun);

      // Reset mid-byte after 3 bits.
      tx_write(8'h4D);
      select_bus();
      tx_write(8'hB2);
      spi_bits(8'hE0, 3);
      #3 reset = 1'b1;
      #1;
      chk("mrst_miso",        {31'd0, miso},        32'd1);
      chk("mrst_miso_oe",     {31'd0, miso_oe},     32'd0);
      chk("mrst_selected",    {31'd0, selected},    32'd0);
      chk("mrst_rx_data",     {24'd0, rx_data},     32'd0);
      chk("mrst_tx_ready",    {31'd0, tx_ready},    32'd1);
      chk("mrst_tx_underrun", {31'd0, tx_underrun}, 32'd0);
      cs_n = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (20) @(negedge clock);
      chk("mrst_no_underrun", underrun_seen, exp_underrun);
      chk("mrst_no_rx",       rx_seen, exp_rx_cnt);
      chk("mrst_selected2",   {31'd0, selected}, 32'd0);
      chk("mrst_miso2",       {31'd0, miso},     32'd1);

      // Everything queued must have been consumed.
      chk("rx_queue_empty",   exp_rx_q.size(),   32'd0);
      chk("miso_queue_empty", exp_miso_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_resp_bs.md
# spi_resp_bs

SPI mode-0 (CPOL=0, CPHA=0) responder byte shifter, MSB first: the peripheral-side counterpart of the SD testbench's SPI byte-initiator. It sits inside the SD-card model/responder logic, oversamples the bus pins on the system clock, and presents whole bytes through a valid pulse (receive) and a one-entry holding register with a ready/valid handshake (transmit). It is fully synchronous to `clock`; `sclk` is treated as data, never as a clock.

## Interface
- SYNC_STAGES, 2, flops per input synchronizer on `sclk`, `mosi`, `cs_n`; minimum 2.
- IDLE_BYTE, 8'hFF, byte shifted out when no transmit byte is loaded.

- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- sclk  in  1  bus clock from the initiator, asynchronous.
- mosi  in  1  initiator-to-responder data.
- cs_n  in  1  active-low chip select.
- miso  out  1  responder-to-initiator data, bit 7 of the transmit shift register.
- miso_oe  out  1  high while selected; external tristate enable.
- tx_data  in  8  next byte to send.
- tx_v  in  1  `tx_data` valid; accepted when `tx_v & tx_ready`.
- tx_ready  out  1  holding register empty.
- tx_underrun  out  1  one-cycle pulse when a byte slot starts with nothing loaded.
- rx_data  out  8  last complete received byte; held until the next one completes.
- rx_v  out  1  one-cycle pulse, `rx_data` updated.
- selected  out  1  synchronized, inverted `cs_n`.

## Operation
- Each bus input passes through a SYNC_STAGES synchronizer (sub-module). Rise/fall of `sclk` are detected by comparing the synchronized value with a one-flop delayed copy. `mosi` uses the same depth, so it stays aligned.
- States:
  - IDLE: `selected=0`, `miso_oe=0`.
  - ACTIVE: entered on the synchronized `cs_n` fall.
  - Leaving: synchronized `cs_n` rise returns to IDLE from any point.
- **Load event:** on entry to ACTIVE, and on the first `sclk` fall after each 8th rise.
  - Transmit shift register loads from the holding register if full (holding then empties).
  - If the holding register is empty but `tx_v` is high that cycle, `tx_data` is bypassed straight in.
  - Otherwise IDLE_BYTE loads and `tx_underrun` pulses.
- **Rise in ACTIVE:** shift `mosi` into the receive register and increment the 3-bit bit counter, wrapping 7→0. On the rise taken with counter 7, `rx_data <= {rx_sr[6:0], mosi}` and `rx_v` pulses on the next cycle.
- **Fall in ACTIVE:** if counter==0 (a byte boundary), perform a load event; otherwise shift the transmit register left, filling with 1.
- **Edges in IDLE:** ignored.
- **cs_n rise mid-byte:**
  - Counter is cleared.
  - Partial receive bits are discarded, with no `rx_v`.
  - The transmit shift register is discarded.
  - The holding register is kept.
- **tx handshake:** `tx_ready = ~holding_full`. A write occurring in the same cycle as a load event is either consumed by bypass (if the holding register was empty) or is impossible (full, `tx_ready=0`). `tx_ready` rises the cycle after consumption.
- **Reset values:**
  - Synchronizers: `sclk`=0, `cs_n`=1, `mosi`=0.
  - Transmit register = IDLE_BYTE (`miso`=1), holding register empty (`tx_ready`=1).
  - `miso_oe`=0, `selected`=0, `rx_data`=0, `rx_v`=0, `tx_underrun`=0, counter=0.
- Reset mid-byte aborts everything to reset values; no pulses are emitted.

## Timing
- Pin edge to internal detection: SYNC_STAGES+1 clocks.
- `miso` update after a pin `sclk` fall: SYNC_STAGES+1 clocks (registered output).
- `rx_v` asserts SYNC_STAGES+2 clocks after the pin `sclk` rise of bit 0 (the LSB).
- Requirement on the initiator: `sclk` high and low phases each ≥ SYNC_STAGES+2 `clock` periods (4 for the default; matches a divide-by-8 initiator).
- First bit: `miso` presents bit 7 of the loaded byte SYNC_STAGES+1 clocks after the pin `cs_n` fall. The initiator must wait at least that long before the first rise.
- To avoid underrun, the next byte must be written any time before the 8th `sclk` fall detection of the current byte.

## Structure
- `spi_pkg`: BYTE_W=8, BITCNT_W=3, default IDLE_BYTE, state enum {IDLE, ACTIVE}.
- Sub-module `sync_ff` (parameter STAGES, parameter RESET_VAL), instantiated three times.
- Everything else in `spi_resp_bs`.

## Test plan
- **Basic exchange:**
  - Stimulus: preload 8'hA5, select, initiator sends 8'h3C.
  - Response: `miso` stream 1,0,1,0,0,1,0,1; `rx_data`=8'h3C; a single `rx_v` pulse; `tx_ready` high after the load.
- **Underrun:**
  - Stimulus: select with the holding register empty and `tx_v`=0.
  - Response: one `tx_underrun` pulse; `miso` sends 8'hFF; receive still works.
- **Back-to-back:**
  - Stimulus: write 8'h01, then 8'h02 while byte 1 shifts; initiator sends 8'h55, 8'hAA.
  - Response: `miso` carries 01 then 02 with no gap; `rx_v` pulses twice with 55, AA.
- **Bypass:**
  - Stimulus: `tx_v` with 8'h7E in the exact cycle of the byte-boundary load, holding register empty.
  - Response: 8'h7E is sent; no underrun.
- **Abort:**
  - Stimulus: deassert `cs_n` after 5 rises.
  - Response: no `rx_v`; `miso_oe`=0; the next select starts at bit 7 with the held byte intact.
- **Reset mid-byte:**
  - Stimulus: assert `reset` asynchronously after 3 bits.
  - Response: all outputs go to reset values immediately; no spurious `rx_v` or `tx_underrun` after release.
